// File: rtl/buffer_shift_sequencer.sv
// Per-job controller for the buffer shift register array: paces the upstream
// word stream, issues the shift control codes, and drives the column mux
// selects, zero mask and the output-valid flag.
module buffer_shift_sequencer #(
  parameter int unsigned X_MAC      = 4,
  parameter int unsigned MUXCONTROL = 4,
  parameter int unsigned WCNT_W     = 8,
  parameter int unsigned OUT_LAT    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_pad,
  input  logic [WCNT_W-1:0]       i_cmd_words,
  input  logic [X_MAC*2-1:0]      i_cmd_mux,
  input  logic [X_MAC-1:0]        i_cmd_zero,
  input  logic                    i_din_valid,
  output logic                    o_din_ready,
  output logic [MUXCONTROL-1:0]   o_control,
  output logic [X_MAC*2-1:0]      o_buffermux,
  output logic [X_MAC-1:0]        o_iszero,
  output logic                    o_out_valid,
  output logic                    o_job_done
);

  localparam logic [MUXCONTROL-1:0] CodePadInit1  = MUXCONTROL'(0);
  localparam logic [MUXCONTROL-1:0] CodePadUinit1 = MUXCONTROL'(2);
  localparam logic [MUXCONTROL-1:0] CodePadUinit2 = MUXCONTROL'(3);
  localparam logic [MUXCONTROL-1:0] CodeUpdInit1  = MUXCONTROL'(4);
  localparam logic [MUXCONTROL-1:0] CodeUpdUinit1 = MUXCONTROL'(6);
  localparam logic [MUXCONTROL-1:0] CodeUpdUinit2 = MUXCONTROL'(7);
  localparam logic [MUXCONTROL-1:0] CodePadEnd3   = MUXCONTROL'(8);
  localparam logic [MUXCONTROL-1:0] CodePadEnd4   = MUXCONTROL'(9);
  // No case in the array matches this code, so its registers hold.
  localparam logic [MUXCONTROL-1:0] CodeHold      = '1;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLo,
    StHi,
    StEndA,
    StEndB,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic                  r_pad;
  logic [WCNT_W-1:0]     r_remain;
  logic [WCNT_W-1:0]     w_remain_d;
  logic [X_MAC*2-1:0]    r_mux;
  logic [X_MAC-1:0]      r_zero;
  logic [MUXCONTROL-1:0] r_control;
  logic [MUXCONTROL-1:0] w_code;
  logic                  w_ready;
  logic                  w_done;
  logic                  w_latch;
  // Valid tag aligned with o_control, then OUT_LAT further stages.
  logic                  r_tag;
  logic [OUT_LAT-1:0]    r_vpipe;
  // Job-active history; keeps the mask applied while the tail drains.
  logic [OUT_LAT:0]      r_busy;
  logic                  w_zone;
  logic [X_MAC*2-1:0]    r_buffermux;
  logic [X_MAC-1:0]      r_iszero;
  logic                  r_job_done;

  // Next-state, code selection and upstream handshake.
  always_comb begin
    w_state_d  = r_state;
    w_remain_d = r_remain;
    w_code     = CodeHold;
    w_ready    = 1'b0;
    w_done     = 1'b0;
    w_latch    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_latch = 1'b1;
          if (i_cmd_words == '0) begin
            w_state_d = StDone;
          end else begin
            w_state_d  = StInit;
            w_remain_d = i_cmd_words - 1'b1;
          end
        end
      end
      StInit: begin
        if (i_din_valid) begin
          w_code  = r_pad ? CodePadInit1 : CodeUpdInit1;
          w_ready = 1'b1;
          if (r_remain != '0) w_state_d = StLo;
          else                w_state_d = r_pad ? StEndA : StDone;
        end
      end
      StLo: begin
        if (i_din_valid) begin
          w_code    = r_pad ? CodePadUinit1 : CodeUpdUinit1;
          w_state_d = StHi;
        end
      end
      StHi: begin
        // Word was already seen valid in LO and is still held upstream.
        w_code     = r_pad ? CodePadUinit2 : CodeUpdUinit2;
        w_ready    = 1'b1;
        w_remain_d = r_remain - 1'b1;
        if (r_remain == WCNT_W'(1)) w_state_d = r_pad ? StEndA : StDone;
        else                        w_state_d = StLo;
      end
      StEndA: begin
        w_code    = CodePadEnd4;
        w_state_d = StEndB;
      end
      StEndB: begin
        w_code    = CodePadEnd3;
        w_state_d = StDone;
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_zone = |r_busy;

  // State, job latches, registered code and the aligned side-band pipelines.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_pad       <= 1'b0;
      r_remain    <= '0;
      r_mux       <= '0;
      r_zero      <= '0;
      r_control   <= CodeHold;
      r_tag       <= 1'b0;
      r_vpipe     <= '0;
      r_busy      <= '0;
      r_buffermux <= '0;
      r_iszero    <= '1;
      r_job_done  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_remain  <= w_remain_d;
      if (w_latch) begin
        r_pad  <= i_cmd_pad;
        r_mux  <= i_cmd_mux;
        r_zero <= i_cmd_zero;
      end
      r_control  <= w_code;
      r_tag      <= (w_code != CodeHold);
      r_vpipe[0] <= r_tag;
      for (int i = 1; i < int'(OUT_LAT); i++) r_vpipe[i] <= r_vpipe[i-1];
      r_busy[0]  <= (r_state != StIdle);
      for (int i = 1; i <= int'(OUT_LAT); i++) r_busy[i] <= r_busy[i-1];
      // One cycle behind o_control so selects meet data at the mux stage.
      r_buffermux <= w_zone ? r_mux : '0;
      r_iszero    <= w_zone ? r_zero : '1;
      r_job_done  <= w_done;
    end
  end

  assign o_cmd_ready = (r_state == StIdle);
  // A word held across a reset cycle must not be consumed.
  assign o_din_ready = w_ready & ~i_rst;
  assign o_control   = r_control;
  assign o_buffermux = r_buffermux;
  assign o_iszero    = r_iszero;
  assign o_out_valid = r_vpipe[OUT_LAT-1];
  assign o_job_done  = r_job_done;

endmodule

// File: doc/buffer_shift_sequencer.md
Name: buffer_shift_sequencer

Overview:
Per-job controller for the buffer shift register array. It drives the 4-bit shift control code, the per-column buffer mux selects and the per-column zero mask. It paces the upstream 32-bit word stream with a valid/ready handshake and flags when shifted, muxed output is valid. One job is one row of input words, padded or unpadded, described by a single command beat.

Parameters:
X_MAC, 4, columns per mesh row; buffermux is 2 bits per column
MUXCONTROL, 4, width of the shift control code
WCNT_W, 8, width of the job word count
OUT_LAT, 2, cycles from an issued control code to valid data at the array's dout (reg stage plus mux stage)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  job command valid
cmd_ready  out  1  high only in IDLE
cmd_pad  in  1  1 = padded job, 0 = unpadded
cmd_words  in  WCNT_W  number of 32-bit input words in the job
cmd_mux  in  X_MAC*2  column mux selects for the job
cmd_zero  in  X_MAC  column zero mask for the job
din_valid  in  1  upstream word valid; must hold the word until din_ready
din_ready  out  1  word consumed this cycle
control  out  MUXCONTROL  shift code to the array
buffermux  out  X_MAC*2  to the array
iszero  out  X_MAC  to the array
out_valid  out  1  array dout holds a valid window this cycle
job_done  out  1  one-cycle pulse after the final code of a job issues

Behaviour:
- Codes used:
  - PAD_INIT_1 = 0, PAD_UINIT_1 = 2, PAD_UINIT_2 = 3
  - UPAD_INIT_1 = 4, UPAD_UINIT_1 = 6, UPAD_UINIT_2 = 7
  - PAD_END_3 = 8, PAD_END_4 = 9
  - HOLD = 4'hF: no case matches in the array, so its registers hold.
- Reset values:
  - control = HOLD
  - buffermux = 0, iszero = all 1s (zeroes the output)
  - din_ready = 0, out_valid = 0, job_done = 0
  - state = IDLE, word counter = 0, valid pipeline cleared
- States: IDLE, INIT, LO, HI, END_A, END_B, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch pad, words, mux and zero.
  - cmd_words == 0 -> go to DONE.
  - Otherwise -> INIT, with remaining count = cmd_words - 1.
- INIT:
  - If din_valid: issue PAD_INIT_1 (pad) or UPAD_INIT_1 (unpad) and assert din_ready.
  - Then remaining > 0 -> LO; else pad -> END_A, unpad -> DONE.
  - If !din_valid: issue HOLD and stay.
- LO:
  - If din_valid: issue PAD_UINIT_1 or UPAD_UINIT_1, din_ready = 0, go to HI.
  - Else issue HOLD and stay.
- HI:
  - Issue PAD_UINIT_2 or UPAD_UINIT_2 and assert din_ready.
  - The held word needs no valid check.
  - Decrement remaining. If remaining was 1: pad -> END_A, unpad -> DONE. Else -> LO.
- END_A issues PAD_END_4 -> END_B. END_B issues PAD_END_3 -> DONE.
- DONE: issue HOLD, pulse job_done for one cycle, go to IDLE. A new command can be accepted the following cycle.
- The control output is registered: the code decided in cycle t appears on control at t+1.
- buffermux/iszero:
  - Driven from the latched cmd_mux/cmd_zero, delayed one further cycle relative to control, so they meet the data at the array's mux stage.
  - Outside a job (IDLE, and the OUT_LAT cycles after DONE drain), iszero = all 1s.
- out_valid: every non-HOLD code is tagged 1. The tag goes through a pipeline of depth OUT_LAT aligned with control, so out_valid rises OUT_LAT cycles after that code appears on control. HOLD codes produce no out_valid.
- Stalls: a LO stall leaves the array registers untouched via HOLD. out_valid gaps match the stall exactly.
- Reset mid-job:
  - The next cycle shows all reset values.
  - Any in-flight out_valid tags are discarded.
  - A word being held upstream is not consumed.
- cmd_valid outside IDLE is ignored (cmd_ready = 0). A din_valid outside INIT/LO/HI is not consumed.

Test Plan:
- Unpadded, cmd_words=3, din_valid held 1 -> control sequence 4,6,7,6,7 then F. din_ready pulses on codes 4, 7, 7 (3 words). 5 out_valid pulses beginning 2 cycles after the first code. job_done one cycle after the last 7.
- Padded, cmd_words=2 -> control sequence 0,2,3,9,8,F. 5 out_valid pulses. buffermux = cmd_mux (e.g. 8'b11_10_01_00) trails control by one cycle. iszero = 0 during the job, all 1s before and after.
- Padded, cmd_words=1 -> control sequence 0,9,8. Exactly 1 din_ready. 3 out_valid pulses.
- Stall: unpadded, cmd_words=2, din_valid dropped for 3 cycles before the second word -> control 4,F,F,F,6,7. out_valid shows a matching 3-cycle gap. No extra din_ready.
- cmd_words=0 -> no codes issued. job_done 2 cycles after the accept (accept -> DONE -> pulse). cmd_ready high again 1 cycle later. No din_ready.
- rst asserted during HI of a 4-word job -> next cycle control=F, out_valid=0, din_ready=0, iszero=1111, cmd_ready=1. A following 1-word unpadded job runs cleanly: control 4 then F.
